// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one of CPUS L1 requesters access to the coherence bus.
// Optional grant-timeout watchdog is compiled in when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int CPUS           = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int ID_W          = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  logic            txn_done,
  output logic [CPUS-1:0] grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_wen,
  output logic            arb_error
);

  if (CPUS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("bus_arbiter: CPUS and TIMEOUT_CYCLES must both be at least 2");
  end

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  arb_state_t      state_reg, state_next;
  logic [ID_W-1:0] last_id_reg, last_id_next;
  logic [CPUS-1:0] grant_reg, grant_next;
  logic            valid_reg, valid_next;
  logic [ID_W-1:0] id_reg, id_next;
  logic            wen_reg, wen_next;
  logic            err_next;

  logic [CPUS-1:0]   active;
  logic [2*CPUS-1:0] req_rot;
  logic              sel_found;
  int                sel_off;
  int                sel_sum;
  logic [ID_W-1:0]   sel_id;
  logic [CPUS-1:0]   sel_onehot;

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_active
    assign active[gi] = dREN[gi] | dWEN[gi];
  end

  // Rotate the request vector so bit 0 is the CPU right after last_id, then take the lowest set bit.
  always_comb begin
    req_rot   = {active, active} >> (int'(last_id_reg) + 1);
    sel_found = 1'b0;
    sel_off   = 0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sel_found = 1'b1;
        sel_off   = i;
      end
    end
    sel_sum = int'(last_id_reg) + 1 + sel_off;
    if (sel_sum >= CPUS) begin
      sel_sum = sel_sum - CPUS;
    end
    sel_id     = ID_W'(sel_sum);
    sel_onehot = CPUS'(1) << sel_id;
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg;
  logic             timeout_hit;

  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign arb_error   = err_reg;
`else
  logic timeout_hit;

  assign timeout_hit = 1'b0;
  assign arb_error   = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    last_id_next = last_id_reg;
    grant_next   = grant_reg;
    valid_next   = valid_reg;
    id_next      = id_reg;
    wen_next     = wen_reg;
    err_next     = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_next     = cnt_reg;
`endif
    case (state_reg)
      ARB_IDLE: begin
        if (sel_found) begin
          state_next = ARB_GRANT;
          grant_next = sel_onehot;
          valid_next = 1'b1;
          id_next    = sel_id;
          // A pending write-back is serviced ahead of the same CPU's read.
          wen_next   = |(dWEN & sel_onehot);
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (txn_done || timeout_hit) begin
          state_next   = ARB_RELEASE;
          grant_next   = '0;
          valid_next   = 1'b0;
          id_next      = '0;
          wen_next     = 1'b0;
          last_id_next = id_reg;
          err_next     = ~txn_done;
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_next = cnt_reg + 1'b1;
`endif
        end
      end
      ARB_RELEASE: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
        valid_next = 1'b0;
        id_next    = '0;
        wen_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= ARB_IDLE;
      last_id_reg <= ID_W'(CPUS - 1);
      grant_reg   <= '0;
      valid_reg   <= 1'b0;
      id_reg      <= '0;
      wen_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_id_reg <= last_id_next;
      grant_reg   <= grant_next;
      valid_reg   <= valid_next;
      id_reg      <= id_next;
      wen_reg     <= wen_next;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_next;
`endif

  assign grant       = grant_reg;
  assign grant_valid = valid_reg;
  assign grant_id    = id_reg;
  assign grant_wen   = wen_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter, checked against a
// transaction-level model of owner / turnaround / round-robin pointer.
module tb_bus_arbiter;
  localparam int CPUS = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TO     = 8;
  localparam bit TO_ON  = 1'b1;
`else
  localparam int TO     = 256;
  localparam bit TO_ON  = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [CPUS-1:0] dREN = '0;
  logic [CPUS-1:0] dWEN = '0;
  logic            txn_done = 1'b0;
  logic [CPUS-1:0] grant;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            grant_wen;
  logic            arb_error;

  bus_arbiter #(.CPUS(CPUS), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .txn_done(txn_done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .grant_wen(grant_wen), .arb_error(arb_error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: who owns the bus, how many turnaround cycles remain, who was served last.
  int   m_owner = -1;
  int   m_last  = CPUS - 1;
  int   m_cool  = 0;
  int   m_held  = 0;
  logic m_wen   = 1'b0;
  logic m_err   = 1'b0;

  task automatic model_step();
    m_err = 1'b0;
    if (RST) begin
      m_owner = -1; m_last = CPUS - 1; m_cool = 0; m_held = 0; m_wen = 1'b0;
    end else if (m_owner >= 0) begin
      if (txn_done || (TO_ON && m_held == TO - 1)) begin
        m_err   = !txn_done;
        m_last  = m_owner;
        m_owner = -1;
        m_wen   = 1'b0;
        m_cool  = 1;
      end else begin
        m_held++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 1; k <= CPUS && m_owner < 0; k++) begin
        int c;
        c = (m_last + k) % CPUS;
        if ((((dREN | dWEN) >> c) & 4'b1) != 0) begin
          m_owner = c;
          m_wen   = ((dWEN >> c) & 4'b1) != 0;
          m_held  = 0;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    return {23'd0, g, (m_owner >= 0), (m_owner >= 0) ? 2'(m_owner) : 2'd0, m_wen, m_err};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {23'd0, grant, grant_valid, grant_id, grant_wen, arb_error};
  endfunction

  task automatic cycle(input logic [3:0] r, input logic [3:0] w, input logic td, input logic rs);
    dREN = r; dWEN = w; txn_done = td; RST = rs;
    @(posedge CLK);
    model_step();
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    cycle(4'b0, 4'b0, 1'b0, 1'b1);
    cycle(4'b0, 4'b0, 1'b0, 1'b1);
    cycle(4'b0, 4'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int seen;
    int got_cycles;
    int err_pulses;
    logic [3:0] r, w;

    @(posedge CLK); #1;
    do_reset();
    check("reset_outputs", dut_vec(), 32'd0);

    // txn_done in idle with no requests is ignored
    cycle(4'b0, 4'b0, 1'b1, 1'b0);
    check("idle_txn_ignored", dut_vec(), 32'd0);

    // single read request from CPU 2, then release with a one-cycle turnaround
    cycle(4'b0100, 4'b0, 1'b0, 1'b0);
    check("single_grant", {28'd0, grant}, 32'b0100);
    check("single_id", {30'd0, grant_id}, 32'd2);
    check("single_wen", {31'd0, grant_wen}, 32'd0);
    cycle(4'b0100, 4'b0, 1'b1, 1'b0);
    check("single_release", {28'd0, grant}, 32'd0);
    cycle(4'b0100, 4'b0, 1'b0, 1'b0);
    check("turnaround_no_grant", {31'd0, grant_valid}, 32'd0);
    cycle(4'b0100, 4'b0, 1'b0, 1'b0);
    check("regrant_after_turnaround", {28'd0, grant}, 32'b0100);

    // all four requesting: round-robin order 0,1,2,3,0
    do_reset();
    for (int n = 0; n < 5; n++) begin
      seen = 0;
      while (!grant_valid && seen < 10) begin
        cycle(4'b1111, 4'b0, 1'b0, 1'b0);
        seen++;
      end
      check("rr_grant_seen", {31'd0, grant_valid}, 32'd1);
      check("rr_order", {30'd0, grant_id}, 32'(n % CPUS));
      cycle(4'b1111, 4'b0, 1'b0, 1'b0);
      cycle(4'b1111, 4'b0, 1'b1, 1'b0);
    end

    // read+write from CPU 1: write-back wins and stays latched when dWEN drops
    do_reset();
    cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
    check("wb_id", {30'd0, grant_id}, 32'd1);
    check("wb_wen", {31'd0, grant_wen}, 32'd1);
    cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    check("wb_wen_held", {31'd0, grant_wen}, 32'd1);
    check("wb_grant_held", {28'd0, grant}, 32'b0010);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

    // async reset mid-grant of CPU 2, then CPU 2 wins again against CPU 3
    do_reset();
    cycle(4'b0100, 4'b0, 1'b0, 1'b0);
    cycle(4'b0100, 4'b0, 1'b0, 1'b0);
    cycle(4'b0100, 4'b0, 1'b0, 1'b0);
    check("pre_reset_grant", {28'd0, grant}, 32'b0100);
    RST = 1'b1;
    #1;
    check("async_reset_outputs", dut_vec(), 32'd0);
    cycle(4'b1100, 4'b0, 1'b0, 1'b1);
    cycle(4'b1100, 4'b0, 1'b0, 1'b0);
    check("post_reset_id", {30'd0, grant_id}, 32'd2);
    cycle(4'b1100, 4'b0, 1'b1, 1'b0);

`ifdef BUS_ARB_TIMEOUT_EN
    // timeout: CPU 0 held 8 cycles, single error pulse, CPU 1 follows
    do_reset();
    got_cycles = 0;
    err_pulses = 0;
    for (int n = 0; n < 12; n++) begin
      cycle(4'b0011, 4'b0, 1'b0, 1'b0);
      if (grant == 4'b0001) got_cycles++;
      if (arb_error) err_pulses++;
    end
    check("timeout_hold_cycles", 32'(got_cycles), 32'd8);
    check("timeout_err_pulses", 32'(err_pulses), 32'd1);
    check("timeout_next_grant", {28'd0, grant}, 32'b0010);
    cycle(4'b0000, 4'b0, 1'b1, 1'b0);
`endif

    // randomized traffic against the model
    do_reset();
    r = 4'b0;
    w = 4'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) w = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      cycle(r, w, ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0));
    end
    // long stretch without txn_done exercises the hold / timeout path
    for (int n = 0; n < 30; n++) cycle(4'b1111, 4'b0101, 1'b0, 1'b0);
    cycle(4'b0, 4'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
